mem_port_arbiter: RTL and testbench

- Shares the single external memory bus between instruction fetch (IF) and data access (MEM) in the 5-stage MIPS pipeline.
- Turns both requests into a sequence of bus transactions.
- Raises the stall requests that the pipeline controller consumes as stop_from_pc and stop_from_mem.
- Takes the controller's flush output and uses it to cancel accesses that have not yet been issued.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory bus between instruction fetch and data access.
// Data has priority over fetch. Flush cancels any access that has not been issued yet.
module mem_port_arbiter #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, DM_WAIT, IF_WAIT, RELEASE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t      state;
  logic        pend_if;
  logic [31:0] if_addr_q;
  logic [15:0] wait_cnt;
  logic        timeout;

  // The wait counter reaches WAIT_MAX on the edge that ends this cycle.
  assign timeout  = (wait_cnt == WAIT_LAST);
  assign if_stall = !rst && if_req && (state != RELEASE);
  assign dm_stall = !rst && dm_req && (state != RELEASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_if   <= 1'b0;
      if_addr_q <= 32'h0;
      wait_cnt  <= 16'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      dm_rdata  <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && (if_req || dm_req)) begin
            pend_if   <= if_req;
            if_addr_q <= if_addr;
            wait_cnt  <= 16'h0;
            bus_req   <= 1'b1;
            if (dm_req) begin
              bus_we    <= dm_we;
              bus_sel   <= dm_sel;
              bus_addr  <= dm_addr;
              bus_wdata <= dm_wdata;
              state     <= DM_WAIT;
            end else begin
              bus_we    <= 1'b0;
              bus_sel   <= 4'b1111;
              bus_addr  <= if_addr;
              bus_wdata <= 32'h0;
              state     <= IF_WAIT;
            end
          end
        end

        DM_WAIT: begin
          if (bus_ack || timeout) begin
            bus_req  <= 1'b0;
            dm_rdata <= bus_ack ? bus_rdata : 32'h0;
            bus_err  <= !bus_ack;
            pend_if  <= pend_if && !flush;
            state    <= (pend_if && !flush) ? IF_WAIT : RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 16'h1;
            if (flush) pend_if <= 1'b0;
          end
        end

        IF_WAIT: begin
          // bus_req low here means this is the one-cycle gap before a queued fetch.
          if (!bus_req) begin
            if (flush) begin
              pend_if <= 1'b0;
              state   <= RELEASE;
            end else begin
              bus_req   <= 1'b1;
              wait_cnt  <= 16'h0;
              bus_we    <= 1'b0;
              bus_sel   <= 4'b1111;
              bus_addr  <= if_addr_q;
              bus_wdata <= 32'h0;
            end
          end else if (bus_ack || timeout) begin
            bus_req  <= 1'b0;
            if_rdata <= bus_ack ? bus_rdata : 32'h0;
            bus_err  <= !bus_ack;
            pend_if  <= 1'b0;
            state    <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 16'h1;
          end
        end

        RELEASE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: the bench acts as the bus slave and predicts
// every cycle from a per-request timeline (transaction durations, gap, release cycle).
module tb_mem_port_arbiter;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, dm_req, dm_we, bus_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_stall, dm_stall, bus_req, bus_we, bus_err;
  logic [3:0]  bus_sel;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_dm_rdata = 32'h0;

  mem_port_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One request episode, starting in IDLE just after a clock edge. k = bus wait cycles
  // before ack; k >= WAIT_MAX means no ack (timeout). flush_at = cycle to pulse flush
  // (-1 none, -2 the release cycle); flush_idle pulses flush in a leading IDLE cycle.
  task automatic applyStimulus(input bit do_dm, input bit do_if, input bit we,
                               input logic [3:0] sel, input logic [31:0] daddr,
                               input logic [31:0] wdata, input logic [31:0] iaddr,
                               input int k1, input int k2, input int flush_at_in,
                               input bit flush_idle, input logic [31:0] rd1,
                               input logic [31:0] rd2);
    bit err1, err2, has2, tx1_dm;
    int d1, d2, rel, flush_at;
    tx1_dm = do_dm;
    err1 = (k1 >= WAIT_MAX);
    err2 = (k2 >= WAIT_MAX);
    d1 = err1 ? WAIT_MAX : k1 + 1;
    d2 = err2 ? WAIT_MAX : k2 + 1;
    has2 = do_dm && do_if && !(flush_at_in >= 1 && flush_at_in <= d1);
    rel = has2 ? d1 + 2 + d2 : d1 + 1;
    flush_at = (flush_at_in == -2) ? rel : flush_at_in;

    dm_req = do_dm; if_req = do_if; dm_we = we; dm_sel = sel;
    dm_addr = daddr; dm_wdata = wdata; if_addr = iaddr;
    bus_ack = 1'b0; flush = 1'b0;

    if (flush_idle) begin
      flush = 1'b1;
      #1;
      checkOutput("flush_idle_bus_req", 32'(bus_req), 32'd0);
      nextCycle();
      flush = 1'b0;
    end

    for (int t = 0; t <= rel + 1; t++) begin
      bit in1, in2, exp_req;
      in1 = (t >= 1 && t <= d1);
      in2 = has2 && (t >= d1 + 2 && t <= d1 + 1 + d2);
      exp_req = in1 || in2;
      flush = (t == flush_at);
      bus_ack = (in1 && t == d1 && !err1) || (in2 && t == d1 + 1 + d2 && !err2);
      bus_rdata = bus_ack ? (in1 ? rd1 : rd2) : $urandom;
      if (t == rel + 1) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      #1;
      checkOutput("bus_req", 32'(bus_req), 32'(exp_req));
      checkOutput("bus_err", 32'(bus_err),
                  32'((t == d1 + 1 && err1) || (has2 && t == d1 + 2 + d2 && err2)));
      checkOutput("if_stall", 32'(if_stall), 32'(if_req && t != rel));
      checkOutput("dm_stall", 32'(dm_stall), 32'(dm_req && t != rel));
      if (exp_req) begin
        if ((in1 && tx1_dm)) begin
          checkOutput("bus_addr_dm", bus_addr, daddr);
          checkOutput("bus_we_dm", 32'(bus_we), 32'(we));
          checkOutput("bus_sel_dm", 32'(bus_sel), 32'(sel));
          if (we) checkOutput("bus_wdata_dm", bus_wdata, wdata);
        end else begin
          checkOutput("bus_addr_if", bus_addr, iaddr);
          checkOutput("bus_we_if", 32'(bus_we), 32'd0);
          checkOutput("bus_sel_if", 32'(bus_sel), 32'hF);
        end
      end
      if (t == d1) begin
        if (tx1_dm) exp_dm_rdata = err1 ? 32'h0 : rd1;
        else        exp_if_rdata = err1 ? 32'h0 : rd1;
      end
      if (has2 && t == d1 + 1 + d2) exp_if_rdata = err2 ? 32'h0 : rd2;
      if (t == rel) begin
        checkOutput("if_rdata", if_rdata, exp_if_rdata);
        checkOutput("dm_rdata", dm_rdata, exp_dm_rdata);
      end
      nextCycle();
    end
    bus_ack = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    dm_sel = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0; if_addr = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    nextCycle();
    nextCycle();
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_sel", 32'(bus_sel), 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_if_stall", 32'(if_stall), 32'd0);
    checkOutput("rst_dm_stall", 32'(dm_stall), 32'd0);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    nextCycle();

    $display("[TB] directed episodes");
    // single fetch, ack 2 cycles after bus_req
    applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h40, 2, 0, -1, 0, 32'h24080005, 32'h0);
    // store + fetch, immediate acks
    applyStimulus(1, 1, 1, 4'b0011, 32'h100, 32'hDEAD, 32'h44, 0, 0, -1, 0, 32'h11111111, 32'h22222222);
    // load times out
    applyStimulus(1, 0, 0, 4'hF, 32'h200, 32'h0, 32'h0, 9, 0, -1, 0, 32'h33333333, 32'h0);
    // flush during data wait with fetch queued
    applyStimulus(1, 1, 1, 4'hF, 32'h300, 32'hBEEF, 32'h48, 2, 0, 1, 0, 32'h44444444, 32'h55555555);
    // ack exactly on the timeout boundary
    applyStimulus(1, 0, 0, 4'hF, 32'h400, 32'h0, 32'h0, WAIT_MAX - 1, 0, -1, 0, 32'h66666666, 32'h0);
    // flush in IDLE, then served normally
    applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h80, 1, 0, -1, 1, 32'h77777777, 32'h0);

    $display("[TB] reset mid-transaction");
    if_req = 1'b1; if_addr = 32'h90;
    nextCycle();
    nextCycle();
    checkOutput("mid_bus_req_before_rst", 32'(bus_req), 32'd1);
    rst = 1'b1; dm_req = 1'b1;
    #1;
    checkOutput("mid_rst_if_stall", 32'(if_stall), 32'd0);
    checkOutput("mid_rst_dm_stall", 32'(dm_stall), 32'd0);
    nextCycle();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #1;
    checkOutput("mid_rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("mid_rst_if_rdata", if_rdata, 32'h0);
    checkOutput("mid_rst_dm_rdata", dm_rdata, 32'h0);
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    nextCycle();
    applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0, 32'hA0, 0, 0, -1, 0, 32'h88888888, 32'h0);

    $display("[TB] random episodes");
    for (int n = 0; n < 60; n++) begin
      bit ddm, dif;
      int k1, k2, mode, fat, d1;
      ddm = 1'($urandom);
      dif = 1'($urandom);
      if (!ddm && !dif) dif = 1'b1;
      k1 = int'($urandom_range(0, 5));
      k2 = int'($urandom_range(0, 5));
      d1 = (k1 >= WAIT_MAX) ? WAIT_MAX : k1 + 1;
      mode = int'($urandom_range(0, 3));
      fat = (mode == 1) ? int'($urandom_range(1, d1)) : (mode == 2) ? -2 : -1;
      applyStimulus(ddm, dif, 1'($urandom), 4'($urandom), $urandom & 32'hFFFFFFFC,
                    $urandom, $urandom & 32'hFFFFFFFC, k1, k2, fat, mode == 3,
                    $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
